// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared state enums for the ALU result path
package config_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_DONE} state_t;

    typedef enum logic {IDLE, SEND} ser_state_t;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - power-of-two word FIFO with synchronous flush
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Flush dominates both ports so a concurrent push is dropped.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/resp_serializer.sv
// rtl/resp_serializer.sv - queues ALU result words and streams them out LSB byte first
module resp_serializer
    import config_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [WORD_BYTES*DATA_WIDTH-1:0] word_i,
    input  logic                             word_valid_i,
    output logic                             word_ready_o,
    input  logic                             flush_i,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             busy_o
);
    localparam int WW = WORD_BYTES * DATA_WIDTH;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

    ser_state_t    state_q, state_d;
    logic [WW-1:0] shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          flush_pend_q, flush_pend_d;
    logic          pop;
    logic [WW-1:0] head;
    logic          fifo_full, fifo_empty;

    word_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (word_valid_i && word_ready_o),
        .wdata_i (word_i),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    // Outputs are forced quiet while rst_i is high so reset takes effect immediately.
    assign word_ready_o = (!fifo_full || rst_i) && !flush_i;
    assign valid_o      = (state_q == SEND) && !rst_i;
    assign data_o       = valid_o ? shift_q[DATA_WIDTH-1:0] : '0;
    assign busy_o       = !rst_i && ((state_q != IDLE) || !fifo_empty);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        flush_pend_d = flush_pend_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                if (!fifo_empty && !flush_i) begin
                    pop     = 1'b1;
                    shift_d = head;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (ready_i) begin
                    // A flush lets the presented byte complete, then drops the rest of the word.
                    if (flush_i || flush_pend_q) begin
                        state_d      = IDLE;
                        shift_d      = '0;
                        idx_d        = '0;
                        flush_pend_d = 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                        end else begin
                            state_d = IDLE;
                            shift_d = '0;
                        end
                    end else begin
                        shift_d = shift_q >> DATA_WIDTH;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: tb/tb_resp_serializer.sv
// tb/tb_resp_serializer.sv - randomized and directed bench for resp_serializer
module tb_resp_serializer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] word_i = '0;
    logic        word_valid_i = 1'b0;
    logic        word_ready_o;
    logic        flush_i = 1'b0;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [2:0]  count_o;
    logic        busy_o;

    resp_serializer #(.DATA_WIDTH(8), .WORD_BYTES(4), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .flush_i      (flush_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .count_o      (count_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words waiting, bytes of the word on the wire, and a log of sent bytes.
    logic [31:0] mq[$];
    logic [7:0]  bq[$];
    logic [7:0]  sent_b[$];
    int          sent_e[$];
    bit          pend = 0;
    int          edge_n = 0;
    int          last_push_edge = 0;
    int          m_nold;
    bit          m_drop, m_push_ok;

    task automatic load_word(input logic [31:0] w);
        logic [7:0] t;
        for (int b = 0; b < 4; b++) begin
            t = w[8*b +: 8];
            bq.push_back(t);
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        if (rst_i) begin
            mq.delete();
            bq.delete();
            pend = 0;
        end else begin
            m_nold    = mq.size();
            m_push_ok = word_valid_i && (m_nold != DEPTH) && !flush_i;
            if (bq.size() == 0) begin
                pend = 0;
                if (m_nold > 0 && !flush_i) load_word(mq.pop_front());
            end else begin
                m_drop = pend || flush_i;
                if (flush_i) pend = 1;
                if (ready_i) begin
                    sent_b.push_back(bq[0]);
                    sent_e.push_back(edge_n);
                    void'(bq.pop_front());
                    if (m_drop) begin
                        bq.delete();
                        pend = 0;
                    end else if (bq.size() == 0 && m_nold > 0) begin
                        load_word(mq.pop_front());
                    end
                end
            end
            if (flush_i) mq.delete();
            else if (m_push_ok) begin
                mq.push_back(word_i);
                last_push_edge = edge_n;
            end
        end
        #1;
        check("valid_o", valid_o, !rst_i && bq.size() != 0);
        check("data_o", data_o, (!rst_i && bq.size() != 0) ? bq[0] : 8'h00);
        check("count_o", count_o, mq.size());
        check("word_ready_o", word_ready_o, (mq.size() != DEPTH || rst_i) && !flush_i);
        check("busy_o", busy_o, !rst_i && (bq.size() != 0 || mq.size() != 0));
    end

    task automatic push(input logic [31:0] w);
        bit ok = 0;
        word_i       = w;
        word_valid_i = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = word_ready_o;
            @(negedge clk);
        end
        word_valid_i = 1'b0;
        check("push_accept", ok, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy_o; k++) @(negedge clk);
        check("idle_reached", busy_o, 0);
    endtask

    task automatic expect_bytes(input string name, input int mark, input logic [31:0] w);
        logic [7:0] t;
        check({name, "_len"}, sent_b.size() - mark, 4);
        for (int b = 0; b < 4 && mark + b < sent_b.size(); b++) begin
            t = w[8*b +: 8];
            check({name, "_byte"}, sent_b[mark+b], t);
            check({name, "_gap"}, sent_e[mark+b], sent_e[mark] + b);
        end
    endtask

    logic [31:0] fw[6];
    logic [31:0] wa;
    logic [7:0]  tb8;
    int          mark;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset: outputs quiet during reset and on the first cycle after it.
        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ready", word_ready_o, 1);
        check("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_valid", valid_o, 0);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_count", count_o, 0);

        // Single word, ready high: bytes 2 edges after the push, LSB first.
        ready_i = 1'b1;
        mark = sent_b.size();
        push(32'h1234_5678);
        wait_idle();
        expect_bytes("single", mark, 32'h1234_5678);
        if (sent_e.size() > mark) check("single_latency", sent_e[mark] - last_push_edge, 2);

        // Backpressure on byte 0.
        ready_i = 1'b0;
        mark = sent_b.size();
        push(32'h1234_5678);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", valid_o, 1);
            check("stall_data", data_o, 8'h78);
            @(negedge clk);
        end
        ready_i = 1'b1;
        wait_idle();
        expect_bytes("stall", mark, 32'h1234_5678);

        // Full FIFO: one word in the shifter plus DEPTH queued blocks the next push.
        ready_i = 1'b0;
        for (int k = 0; k < 6; k++) fw[k] = $urandom;
        mark = sent_b.size();
        for (int k = 0; k < 5; k++) push(fw[k]);
        check("full_count", count_o, 4);
        check("full_ready", word_ready_o, 0);
        word_i = fw[5];
        word_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_hold_ready", word_ready_o, 0);
            check("full_hold_count", count_o, 4);
        end
        ready_i = 1'b1;
        push(fw[5]);
        wait_idle();
        check("full_len", sent_b.size() - mark, 24);
        for (int k = 0; k < 24 && mark + k < sent_b.size(); k++) begin
            wa  = fw[k/4];
            tb8 = wa[8*(k%4) +: 8];
            check("full_order", sent_b[mark+k], tb8);
            check("full_nogap", sent_e[mark+k], sent_e[mark] + k);
        end

        // Flush while byte 1 of word A is pending with two words queued.
        ready_i = 1'b0;
        wa = 32'hA1A2_A3A4;
        push(wa);
        push(32'hB1B2_B3B4);
        push(32'hC1C2_C3C4);
        check("flush_pre_count", count_o, 2);
        mark = sent_b.size();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("flush_b1_data", data_o, 8'hA3);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_hold_valid", valid_o, 1);
        check("flush_hold_data", data_o, 8'hA3);
        ready_i = 1'b1;
        @(negedge clk);
        check("flush_idle_valid", valid_o, 0);
        repeat (4) @(negedge clk);
        check("flush_len", sent_b.size() - mark, 2);
        if (sent_b.size() >= mark + 2) begin
            check("flush_b0", sent_b[mark], 8'hA4);
            check("flush_b1", sent_b[mark+1], 8'hA3);
        end
        check("flush_busy", busy_o, 0);

        // Reset while byte 2 is presented.
        ready_i = 1'b0;
        push(32'h0102_0304);
        @(negedge clk);
        ready_i = 1'b1;
        repeat (2) @(negedge clk);
        ready_i = 1'b0;
        check("rstmid_b2", data_o, 8'h02);
        rst_i = 1'b1;
        @(negedge clk);
        check("rstmid_valid", valid_o, 0);
        check("rstmid_data", data_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check("rstmid_after_valid", valid_o, 0);
        check("rstmid_after_count", count_o, 0);
        ready_i = 1'b1;
        mark = sent_b.size();
        push(32'hDEAD_BEEF);
        wait_idle();
        expect_bytes("deadbeef", mark, 32'hDEAD_BEEF);

        // Random traffic, checked every cycle by the model.
        for (int k = 0; k < 3000; k++) begin
            word_valid_i = 1'($urandom_range(0, 1));
            word_i       = $urandom;
            ready_i      = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 63) == 0);
            rst_i        = ($urandom_range(0, 255) == 0);
            @(negedge clk);
        end
        word_valid_i = 1'b0;
        flush_i      = 1'b0;
        rst_i        = 1'b0;
        ready_i      = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
